// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with fill level, almost-full/almost-empty
// thresholds, registered or first-word-fall-through read, synchronous flush
// and sticky overflow/underflow flags.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned AF_LEVEL  = 14,
    parameter int unsigned AE_LEVEL  = 2,
    parameter int unsigned FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 wr_inc,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    input  logic                 rd_inc,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_empty,
    output logic                 rd_almost_empty,
    output logic [ADDR_SIZE:0]   level,
    input  logic                 flush,
    input  logic                 clr_err,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_L = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0] AF_L = AF_LEVEL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AE_L = AE_LEVEL[ADDR_SIZE:0];

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE:0]   wr_ptr;
    logic [ADDR_SIZE:0]   rd_ptr;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 wr_en;
    logic                 rd_en;

    // Level and status flags derived from the registered pointers
    always_comb begin
        wr_addr         = wr_ptr[ADDR_SIZE-1:0];
        rd_addr         = rd_ptr[ADDR_SIZE-1:0];
        level           = wr_ptr - rd_ptr;
        wr_full         = (level == DEPTH_L);
        rd_empty        = (level == '0);
        wr_almost_full  = (level >= AF_L);
        rd_almost_empty = (level <= AE_L);
        wr_acc          = wr_inc & ~wr_full;
        rd_acc          = rd_inc & ~rd_empty;
        // flush overrides any accepted transfer in the same cycle
        wr_en           = wr_acc & ~flush;
        rd_en           = rd_acc & ~flush;
    end

    // Pointer update: flush returns both pointers to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are not cleared by reset or flush
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Sticky error flags; a new error in the clr_err cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!flush && wr_inc && wr_full) overflow <= 1'b1;
            else if (clr_err)                overflow <= 1'b0;
            if (!flush && rd_inc && rd_empty) underflow <= 1'b1;
            else if (clr_err)                 underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown combinationally; meaningful only while not empty
            always_comb rd_data = mem[rd_addr];
        end else begin : g_reg
            // Registered read: word appears the cycle after the pop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     rd_data <= '0;
                else if (rd_en) rd_data <= mem[rd_addr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one registered-read and one FWFT instance
// driven by the same inputs, checked against a queue-based scoreboard.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_inc = 1'b0;
    logic       rd_inc = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;

    logic       wr_full0, wr_af0, rd_empty0, rd_ae0, ov0, uf0;
    logic [7:0] rd_data0;
    logic [4:0] level0;
    logic       wr_full1, wr_af1, rd_empty1, rd_ae1, ov1, uf1;
    logic [7:0] rd_data1;
    logic [4:0] level1;

    int total = 0;
    int bad = 0;

    logic [7:0] sb[$];
    logic       m_ov = 1'b0;
    logic       m_uf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_inc(wr_inc), .wr_full(wr_full0),
        .wr_almost_full(wr_af0), .rd_inc(rd_inc), .rd_data(rd_data0), .rd_empty(rd_empty0),
        .rd_almost_empty(rd_ae0), .level(level0), .flush(flush), .clr_err(clr_err),
        .overflow(ov0), .underflow(uf0)
    );

    sync_fifo_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_inc(wr_inc), .wr_full(wr_full1),
        .wr_almost_full(wr_af1), .rd_inc(rd_inc), .rd_data(rd_data1), .rd_empty(rd_empty1),
        .rd_almost_empty(rd_ae1), .level(level1), .flush(flush), .clr_err(clr_err),
        .overflow(ov1), .underflow(uf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        int n;
        n = sb.size();
        chk("level", 32'(level0), 32'(n));
        chk("wr_full", 32'(wr_full0), 32'(n == 16));
        chk("rd_empty", 32'(rd_empty0), 32'(n == 0));
        chk("wr_almost_full", 32'(wr_af0), 32'(n >= 14));
        chk("rd_almost_empty", 32'(rd_ae0), 32'(n <= 2));
        chk("overflow", 32'(ov0), 32'(m_ov));
        chk("underflow", 32'(uf0), 32'(m_uf));
        chk("fwft_level", 32'(level1), 32'(n));
        chk("fwft_empty", 32'(rd_empty1), 32'(n == 0));
        if (n > 0) chk("fwft_head", 32'(rd_data1), 32'(sb[0]));
    endtask

    // One clock of stimulus; the model acts on the pre-edge state.
    task automatic step(input logic wi, input logic [7:0] wd, input logic ri,
                        input logic fl, input logic ce);
        logic       wa;
        logic       ra;
        logic [7:0] exp_rd;
        logic [7:0] held;
        exp_rd  = '0;
        held    = rd_data0;
        wr_inc  = wi;
        wr_data = wd;
        rd_inc  = ri;
        flush   = fl;
        clr_err = ce;
        wa = wi && (sb.size() < 16) && !fl;
        ra = ri && (sb.size() > 0) && !fl;
        if (!fl && wi && sb.size() == 16) m_ov = 1'b1;
        else if (ce)                      m_ov = 1'b0;
        if (!fl && ri && sb.size() == 0)  m_uf = 1'b1;
        else if (ce)                      m_uf = 1'b0;
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        else begin
            if (ra) exp_rd = sb.pop_front();
            if (wa) sb.push_back(wd);
        end
        if (ra) chk("rd_data", 32'(rd_data0), 32'(exp_rd));
        else    chk("rd_data_hold", 32'(rd_data0), 32'(held));
        wr_inc  = 1'b0;
        rd_inc  = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        chk_status();
    endtask

    task automatic chk_reset();
        chk("rst_level", 32'(level0), 32'd0);
        chk("rst_empty", 32'(rd_empty0), 32'd1);
        chk("rst_full", 32'(wr_full0), 32'd0);
        chk("rst_ae", 32'(rd_ae0), 32'd1);
        chk("rst_af", 32'(wr_af0), 32'd0);
        chk("rst_ov", 32'(ov0), 32'd0);
        chk("rst_uf", 32'(uf0), 32'd0);
        chk("rst_rd_data", 32'(rd_data0), 32'd0);
        chk("rst_fwft_level", 32'(level1), 32'd0);
    endtask

    initial begin
        // reset state
        #2;
        chk_reset();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: fill with 0x01..0x10, then one write too many
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);

        // 2: drain in order, extra pop, then clear errors
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 3: steady state at level 5 with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);

        // 4: both requests at full, then both requests at empty
        for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 5: FWFT head visible before any pop
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("fwft_a5_data", 32'(rd_data1), 32'hA5);
        chk("fwft_a5_empty", 32'(rd_empty1), 32'd0);

        // 6: flush at level 9 with both requests high, then async reset mid-burst
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_level", 32'(level0), 32'd9);
        step(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, 1'b0);
        wr_inc  = 1'b1;
        rd_inc  = 1'b1;
        wr_data = 8'hDD;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_ov = 1'b0;
        m_uf = 1'b0;
        chk_reset();
        wr_inc = 1'b0;
        rd_inc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
